// File: rtl/c1541_sd_arbiter.sv
// ============================================================================
// Module  : c1541_sd_arbiter
// Purpose : Round-robin sharing of the host SD sector port among the
//           per-drive track-buffer units, one sector at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module c1541_sd_arbiter #(
    parameter int          NUM_REQ = 2,
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic                    sd_clk,
    input  logic                    reset,
    input  logic [32*NUM_REQ-1:0]   req_lba_i,
    input  logic [NUM_REQ-1:0]      req_rd_i,
    input  logic [NUM_REQ-1:0]      req_wr_i,
    output logic [NUM_REQ-1:0]      req_ack_o,
    output logic [NUM_REQ-1:0]      req_buff_wr_o,
    input  logic [8*NUM_REQ-1:0]    req_buff_din_i,
    output logic [NUM_REQ-1:0]      req_err_o,
    output logic [31:0]             sd_lba_o,
    output logic                    sd_rd_o,
    output logic                    sd_wr_o,
    input  logic                    sd_ack_i,
    input  logic                    sd_buff_wr_i,
    output logic [7:0]              sd_buff_din_o,
    output logic                    busy_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [31:0]     lba_q, lba_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [23:0]     cnt_q, cnt_d;
    logic            ack_q;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   cand;
    logic            sel_rd;
    logic            sel_wr;
    logic [31:0]     sel_lba;
    logic            timeout_hit;

    // Round-robin scan starting just after the last granted index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!sel_found && (IW'(i) == cand) && (req_rd_i[i] || req_wr_i[i])) begin
                    sel_found = 1'b1;
                    sel_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        sel_rd  = 1'b0;
        sel_wr  = 1'b0;
        sel_lba = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == sel_idx) begin
                sel_rd  = req_rd_i[i];
                sel_wr  = req_wr_i[i];
                sel_lba = req_lba_i[32*i +: 32];
            end
        end
    end

    assign timeout_hit = (state_q == S_ISSUE) && !sd_ack_i &&
                         (TIMEOUT != 24'd0) && (cnt_q == TIMEOUT);

    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            ack_q   <= sd_ack_i;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (sel_found) begin
                    idx_d   = sel_idx;
                    lba_d   = sel_lba;
                    // A pending write is served first so a dirty track is saved before reload.
                    wr_d    = sel_wr;
                    rd_d    = sel_rd & ~sel_wr;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sd_ack_i) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_XFER;
                end else if (timeout_hit) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ptr_d   = idx_q;
                    state_d = S_IDLE;
                end else if (cnt_q != 24'hFFFFFF) begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_XFER: begin
                if (ack_q && !sd_ack_i) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                ptr_d   = idx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ack_o     = '0;
        req_buff_wr_o = '0;
        req_err_o     = '0;
        sd_buff_din_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == idx_q) begin
                if (state_q == S_XFER) begin
                    req_ack_o[i]     = sd_ack_i;
                    req_buff_wr_o[i] = sd_buff_wr_i;
                    sd_buff_din_o    = req_buff_din_i[8*i +: 8];
                end
                req_err_o[i] = timeout_hit;
            end
        end
    end

    assign sd_lba_o = lba_q;
    assign sd_rd_o  = rd_q;
    assign sd_wr_o  = wr_q;
    assign busy_o   = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_c1541_sd_arbiter.sv
// ============================================================================
// Module  : tb_c1541_sd_arbiter
// Purpose : Directed, table-driven checks of the SD sector port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c1541_sd_arbiter;

    localparam logic [31:0] L0 = 32'h0000_00A5;
    localparam logic [31:0] L1 = 32'h0000_1234;
    localparam logic [7:0]  D0 = 8'hFF;
    localparam logic [7:0]  D1 = 8'h5A;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] req_lba;
    logic [1:0]  req_rd, req_wr, req_ack, req_bwr, req_err;
    logic [15:0] req_din;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_bwr, busy;
    logic [7:0]  sd_din;

    int n_vec = 0;
    int n_bad = 0;
    int bad;
    int ex;

    always #5 clk = ~clk;

    c1541_sd_arbiter #(.NUM_REQ(2), .TIMEOUT(24'd16)) dut (
        .sd_clk        (clk),
        .reset         (reset),
        .req_lba_i     (req_lba),
        .req_rd_i      (req_rd),
        .req_wr_i      (req_wr),
        .req_ack_o     (req_ack),
        .req_buff_wr_o (req_bwr),
        .req_buff_din_i(req_din),
        .req_err_o     (req_err),
        .sd_lba_o      (sd_lba),
        .sd_rd_o       (sd_rd),
        .sd_wr_o       (sd_wr),
        .sd_ack_i      (sd_ack),
        .sd_buff_wr_i  (sd_bwr),
        .sd_buff_din_o (sd_din),
        .busy_o        (busy)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  rd, wr;
        logic        ack, bwr;
        logic        e_rd, e_wr, e_busy;
        logic [1:0]  e_ack, e_bwr, e_err;
        logic [7:0]  e_din;
        logic [31:0] e_lba;
    } vec_t;

    vec_t tv[21];

    function automatic vec_t mk(logic rst, logic [1:0] rd, logic [1:0] wr, logic ack, logic bwr,
                                logic e_rd, logic e_wr, logic e_busy, logic [1:0] e_ack,
                                logic [1:0] e_bwr, logic [1:0] e_err, logic [7:0] e_din,
                                logic [31:0] e_lba);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.ack = ack; v.bwr = bwr;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_busy = e_busy; v.e_ack = e_ack;
        v.e_bwr = e_bwr; v.e_err = e_err; v.e_din = e_din; v.e_lba = e_lba;
        return v;
    endfunction

    function automatic logic [63:0] obs();
        return {15'b0, sd_rd, sd_wr, busy, req_ack, req_bwr, req_err, sd_din, sd_lba};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //              rst rd     wr     ack   bwr  | rd   wr   busy ack    bwr    err    din    lba
        tv[0]  = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 32'h0);
        tv[1]  = mk(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 32'h0);
        tv[2]  = mk(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, L0);
        tv[3]  = mk(1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, L0);
        tv[4]  = mk(1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 2'b00, D0,    L0);
        tv[5]  = mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, D0,    L0);
        tv[6]  = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, D0,    L0);
        tv[7]  = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, L0);
        tv[8]  = mk(1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, L0);
        tv[9]  = mk(1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, L1);
        tv[10] = mk(1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, D1,    L1);
        tv[11] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, D1,    L1);
        tv[12] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, D1,    L1);
        tv[13] = mk(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, L1);
        tv[14] = mk(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, L1);
        tv[15] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, L0);
        tv[16] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, L0);
        tv[17] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, D0,    L0);
        tv[18] = mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00, L0);
        tv[19] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, L0);
        tv[20] = mk(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00, L0);

        reset   = 1'b1;
        req_lba = {L1, L0};
        req_din = {D1, D0};
        req_rd  = 2'b00;
        req_wr  = 2'b00;
        sd_ack  = 1'b0;
        sd_bwr  = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 21; i++) begin
            reset  = tv[i].rst;
            req_rd = tv[i].rd;
            req_wr = tv[i].wr;
            sd_ack = tv[i].ack;
            sd_bwr = tv[i].bwr;
            settle();
            chk($sformatf("vec%0d", i), obs(),
                {15'b0, tv[i].e_rd, tv[i].e_wr, tv[i].e_busy, tv[i].e_ack, tv[i].e_bwr,
                 tv[i].e_err, tv[i].e_din, tv[i].e_lba});
            tick();
        end

        // Single read with a full 512-byte acknowledge
        sd_ack = 1'b0;
        sd_bwr = 1'b0;
        req_rd = 2'b01;
        tick();
        settle();
        chk("rd_issue", {30'b0, sd_rd, sd_wr, sd_lba}, {30'b0, 1'b1, 1'b0, L0});
        sd_ack = 1'b1;
        #1;
        chk("rd_issue_noroute", {62'b0, req_ack}, 64'd0);
        tick();
        req_rd = 2'b00;
        bad = 0;
        for (int b = 0; b < 1024; b++) begin
            sd_bwr = b[0];
            settle();
            if (req_ack !== 2'b01 || req_bwr !== {1'b0, sd_bwr} || sd_din !== D0) bad++;
            tick();
        end
        chk("rd_512_route", 64'(bad), 64'd0);
        sd_ack = 1'b0;
        sd_bwr = 1'b0;
        settle();
        chk("rd_ack_fall", {62'b0, req_ack}, 64'd0);
        tick();
        tick();
        settle();
        chk("rd_idle", {63'b0, busy}, 64'd0);

        // Contention from reset: grants alternate 0,1,0,1,0,1
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        req_rd = 2'b11;
        tick();
        for (int s = 0; s < 6; s++) begin
            ex = s % 2;
            settle();
            chk($sformatf("ctn_grant%0d", s), {31'b0, sd_rd, sd_lba},
                {31'b0, 1'b1, (ex == 1) ? L1 : L0});
            sd_ack = 1'b1;
            tick();
            settle();
            chk($sformatf("ctn_ack%0d", s), {62'b0, req_ack}, 64'd1 << ex);
            req_rd[ex] = 1'b0;
            tick();
            tick();
            sd_ack = 1'b0;
            tick();
            req_rd = (s < 5) ? 2'b11 : 2'b00;
            tick();
            tick();
        end

        // Watchdog expiry on requester 1 with requester 0 waiting
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        req_rd = 2'b10;
        tick();
        req_rd = 2'b11;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            settle();
            if (req_err !== 2'b00 || sd_rd !== 1'b1 || busy !== 1'b1) bad++;
            tick();
        end
        chk("to_wait", 64'(bad), 64'd0);
        settle();
        chk("to_err_pulse", {61'b0, sd_rd, req_err}, {61'b0, 1'b1, 2'b10});
        req_rd = 2'b01;
        tick();
        settle();
        chk("to_drop", {60'b0, sd_rd, busy, req_err}, 64'd0);
        tick();
        settle();
        chk("to_next_grant", {31'b0, sd_rd, sd_lba}, {31'b0, 1'b1, L0});

        // Reset in the middle of a transfer
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        req_rd = 2'b01;
        tick();
        sd_ack = 1'b1;
        tick();
        req_rd = 2'b00;
        for (int b = 0; b < 200; b++) begin
            sd_bwr = 1'b1;
            tick();
            sd_bwr = 1'b0;
            tick();
        end
        reset  = 1'b1;
        sd_bwr = 1'b1;
        tick();
        settle();
        chk("rst_mid", {57'b0, sd_rd, sd_wr, busy, req_ack, req_bwr}, 64'd0);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            if (busy !== 1'b0 || req_ack !== 2'b00 || req_bwr !== 2'b00) bad++;
        end
        chk("rst_ack_ignored", 64'(bad), 64'd0);
        sd_ack = 1'b0;
        sd_bwr = 1'b0;
        req_rd = 2'b11;
        tick();
        settle();
        chk("rst_first_grant", {31'b0, sd_rd, sd_lba}, {31'b0, 1'b1, L0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
